sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM between the fetch-stage instruction port and the memory-stage data port, so the CPU core can run against a unified memory.
- Arbitrates per cycle and drives the shared SRAM.
- Tracks the owner of each in-flight read and routes the returned word to that requester only.
- Gives the data port priority, with a starvation limit that guarantees instruction-fetch progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive denied instruction-request cycles after which the instruction port wins once (range 1..15).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- i_req  in  1  instruction port access request (read only).
- i_addr  in  ADDR_W  instruction address.
- i_gnt  out  1  instruction request accepted this cycle.
- i_rvalid  out  1  i_rdata valid.
- i_rdata  out  DATA_W  instruction read data.
- d_req  in  1  data port access request.
- d_wen  in  DATA_W/8  data byte write enables; all zero means read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  data write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  d_rdata valid.
- d_rdata  out  DATA_W  data read data.
- sram_en  out  1  shared SRAM enable.
- sram_wen  out  DATA_W/8  shared SRAM byte write enables.
- sram_addr  out  ADDR_W  shared SRAM address.
- sram_wdata  out  DATA_W  shared SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid one cycle after an enabled read.
- conflict_cnt  out  CNT_W  saturating count of cycles with both requests asserted.

Behaviour:
- Grant logic is combinational within the cycle. At most one of i_gnt/d_gnt is high. A grant is never asserted without the matching req.
- Default winner on conflict is the data port. The instruction port wins instead when starve_cnt >= STARVE_LIMIT.
- starve_cnt (4-bit, registered):
  - cleared on any i_gnt or when i_req is low;
  - incremented when i_req=1 and i_gnt=0;
  - saturates at 15.
- SRAM drive:
  - sram_en = i_gnt | d_gnt.
  - Address, wen and wdata come from the granted port.
  - Instruction grants force sram_wen=0 and sram_wdata=0.
  - With no grant, all sram outputs are 0.
- Read-owner state machine (registered), states IDLE, RD_I, RD_D. Next state each cycle:
  - RD_I if i_gnt;
  - RD_D if d_gnt with d_wen==0;
  - IDLE otherwise, including a data write.
  - Back-to-back grants are allowed every cycle. The owner register pipelines exactly one cycle.
- Return path:
  - i_rvalid = (state==RD_I); d_rvalid = (state==RD_D).
  - x_rdata = sram_rdata when the matching rvalid is high, else 0.
- Writes complete at grant and produce no rvalid.
- Requesters hold req, addr, wen and wdata stable until they see gnt. Dropping req before gnt is legal and simply withdraws the request.
- conflict_cnt increments in every cycle where i_req & d_req, and saturates at all ones.
- Reset (resetn low, asynchronous, any time):
  - state=IDLE, starve_cnt=0, conflict_cnt=0.
  - All rvalid outputs 0 immediately. A read in flight at reset never returns.
  - Grants and sram outputs are forced to 0 while resetn is low.
- After resetn deasserts, the first grant is possible in the same cycle.
- Simultaneous grant and return: a new grant in cycle N coexists with rvalid for the cycle N-1 grant. Owner tracking keeps them separate.

Test Plan:
- Instruction read only, i_addr=0x100 held 3 cycles, SRAM returns 0xA0+n -> i_gnt high 3 cycles; i_rvalid high in cycles 1..3 with matching data; d_rvalid never high.
- Constant conflict, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; conflict_cnt increments every cycle; i_rvalid once per 5 cycles.
- Data write d_wen=4'b0011, addr=0x8, wdata=0x1234ABCD, then data read of 0x8 -> sram_wen=0011 on the write cycle with no rvalid; d_rvalid exactly one cycle after the read grant.
- Alternating i/d reads back-to-back (I,D,I,D) -> rvalid owners alternate with one-cycle lag; no data crosses to the wrong port.
- resetn pulsed low the cycle after a data read grant -> d_rvalid stays 0, conflict_cnt=0 and starve_cnt=0 after release; the next request is granted normally.
- Hold i_req and d_req for 70000 cycles (CNT_W=16) -> conflict_cnt saturates at 0xFFFF with no wrap.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one synchronous single-port SRAM between an instruction-fetch port
// (read only) and a data port (read/write). The data port wins conflicts
// unless the instruction port has been denied STARVE_LIMIT cycles in a row.
// The owner of each read is registered for one cycle so that the word the
// SRAM returns is steered only to the port that issued the read.
//
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   i_req/i_addr -> i_gnt             instruction request / accept
//   i_rvalid/i_rdata                  instruction read return
//   d_req/d_wen/d_addr/d_wdata        data request (d_wen==0 means read)
//   d_gnt, d_rvalid/d_rdata           data accept / read return
//   sram_en/wen/addr/wdata            shared SRAM drive
//   sram_rdata                        SRAM read data (one cycle after read)
//   conflict_cnt                      saturating count of i_req&d_req cycles
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic [CNT_W-1:0]    conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2
  } owner_e;

  owner_e             state_q, state_d;
  logic [3:0]         starve_q, starve_d;
  logic [CNT_W-1:0]   conflict_q, conflict_d;
  logic               starved;

  assign starved = (starve_q >= 4'(STARVE_LIMIT));

  // Grants are gated by resetn so nothing reaches the SRAM while in reset.
  assign i_gnt = resetn & i_req & (~d_req | starved);
  assign d_gnt = resetn & d_req & ~(i_req & starved);

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (i_gnt) begin
      sram_en   = 1'b1;
      sram_addr = i_addr;
    end else if (d_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = d_wen;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
    end
  end

  // Owner of the read issued this cycle; writes leave nothing to return.
  always_comb begin
    state_d = IDLE;
    if (i_gnt) begin
      state_d = RD_I;
    end else if (d_gnt && (d_wen == '0)) begin
      state_d = RD_D;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!i_req || i_gnt) begin
      starve_d = 4'd0;
    end else if (starve_q != 4'hF) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    conflict_d = conflict_q;
    if (i_req && d_req && !(&conflict_q)) begin
      conflict_d = conflict_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      starve_q   <= 4'd0;
      conflict_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
    end
  end

  // Return path: the registered owner selects which port sees sram_rdata.
  assign i_rvalid     = (state_q == RD_I);
  assign d_rvalid     = (state_q == RD_D);
  assign i_rdata      = i_rvalid ? sram_rdata : '0;
  assign d_rdata      = d_rvalid ? sram_rdata : '0;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int BE_W         = DATA_W / 8;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 16;
  localparam longint CNT_MAX  = (64'd1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt, i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic [BE_W-1:0]   d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              sram_en;
  logic [BE_W-1:0]   sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic [CNT_W-1:0]  conflict_cnt;

  sram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who has been waiting how long, which reads are still
  // owed a return, and how many conflict cycles have been seen.
  int     m_wait;       // consecutive denied instruction cycles
  int     m_owed[$];    // reads awaiting return: 1 = instruction, 2 = data
  longint m_conf;
  bit     last_ig, last_dg;

  task automatic model_clear();
    m_wait = 0;
    m_owed.delete();
    m_conf = 0;
  endtask

  // One clock cycle: drive inputs after the falling edge, check settled
  // outputs against the model, then advance the model past the rising edge.
  task automatic step(input logic ir, input logic [ADDR_W-1:0] ia,
                      input logic dr, input logic [BE_W-1:0] dw,
                      input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd,
                      input logic [DATA_W-1:0] rd, input bit full);
    bit eig, edg, ret_i, ret_d;
    @(negedge clk);
    i_req = ir; i_addr = ia; d_req = dr; d_wen = dw; d_addr = da; d_wdata = dd;
    sram_rdata = rd;
    #1;
    eig   = ir && (!dr || m_wait >= STARVE_LIMIT);
    edg   = dr && !eig;
    ret_i = (m_owed.size() > 0) && (m_owed[0] == 1);
    ret_d = (m_owed.size() > 0) && (m_owed[0] == 2);
    if (full) begin
      check_val("i_gnt", i_gnt, eig);
      check_val("d_gnt", d_gnt, edg);
      check_val("sram_en", sram_en, eig || edg);
      check_val("sram_addr", sram_addr, eig ? ia : (edg ? da : '0));
      check_val("sram_wen", sram_wen, edg ? dw : '0);
      check_val("sram_wdata", sram_wdata, edg ? dd : '0);
      check_val("i_rvalid", i_rvalid, ret_i);
      check_val("d_rvalid", d_rvalid, ret_d);
      check_val("i_rdata", i_rdata, ret_i ? rd : '0);
      check_val("d_rdata", d_rdata, ret_d ? rd : '0);
      check_val("conflict_cnt", conflict_cnt, m_conf);
    end
    last_ig = eig;
    last_dg = edg;
    if (m_owed.size() > 0) void'(m_owed.pop_front());
    if (eig) m_owed.push_back(1);
    else if (edg && dw == '0) m_owed.push_back(2);
    if (!ir || eig) m_wait = 0;
    else if (m_wait < 15) m_wait++;
    if (ir && dr && m_conf < CNT_MAX) m_conf++;
  endtask

  bit              ip, dp;
  logic [ADDR_W-1:0] pa_i, pa_d;
  logic [BE_W-1:0]   pw;
  logic [DATA_W-1:0] pd;
  int              pattern_ok;

  initial begin
    resetn = 1'b0;
    i_req = 0; i_addr = '0; d_req = 0; d_wen = '0; d_addr = '0; d_wdata = '0;
    sram_rdata = '0;
    model_clear();

    // In reset: requests present, nothing may be granted or driven.
    @(negedge clk);
    i_req = 1; d_req = 1; d_addr = 32'h44; i_addr = 32'h40;
    #1;
    check_val("rst_i_gnt", i_gnt, 1'b0);
    check_val("rst_d_gnt", d_gnt, 1'b0);
    check_val("rst_sram_en", sram_en, 1'b0);
    check_val("rst_sram_addr", sram_addr, '0);
    check_val("rst_conflict", conflict_cnt, '0);
    check_val("rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
    @(negedge clk);
    resetn = 1'b1;
    i_req = 0; d_req = 0;

    // Instruction-only reads of 0x100, SRAM returns 0xA0+n.
    for (int n = 0; n < 3; n++) step(1, 32'h100, 0, '0, '0, '0, 32'hA0 + n, 1);
    step(0, '0, 0, '0, '0, '0, 32'hA3, 1);

    // Constant conflict: D,D,D,D,I repeating.
    pattern_ok = 1;
    for (int n = 0; n < 15; n++) begin
      step(1, 32'h200 + n, 1, '0, 32'h300 + n, '0, $urandom, 1);
      if (last_ig != ((n % 5) == 4)) pattern_ok = 0;
    end
    check_val("starve_pattern", pattern_ok, 1);
    step(0, '0, 0, '0, '0, '0, $urandom, 1);

    // Partial write then read of 0x8.
    step(0, '0, 1, 4'b0011, 32'h8, 32'h1234ABCD, $urandom, 1);
    step(0, '0, 1, 4'b0000, 32'h8, '0, $urandom, 1);
    step(0, '0, 0, '0, '0, '0, 32'h0000ABCD, 1);
    step(0, '0, 0, '0, '0, '0, $urandom, 1);

    // Alternating instruction/data reads back-to-back.
    for (int n = 0; n < 4; n++)
      step(n % 2 == 0, 32'h400 + n, n % 2 == 1, '0, 32'h500 + n, '0, $urandom, 1);
    step(0, '0, 0, '0, '0, '0, $urandom, 1);

    // Reset pulsed the cycle after a data read grant.
    step(1, 32'h10, 1, '0, 32'h20, '0, $urandom, 1);
    step(0, '0, 1, '0, 32'h24, '0, $urandom, 1);
    @(negedge clk);
    resetn = 1'b0;
    i_req = 1; d_req = 1;
    #1;
    check_val("rstmid_d_rvalid", d_rvalid, 1'b0);
    check_val("rstmid_gnt", {i_gnt, d_gnt}, 2'b00);
    check_val("rstmid_conflict", conflict_cnt, '0);
    model_clear();
    @(negedge clk);
    resetn = 1'b1;
    i_req = 0; d_req = 0;
    // A fresh conflict right away must go to data (starve counter cleared).
    step(1, 32'h30, 1, '0, 32'h34, '0, $urandom, 1);
    check_val("post_rst_dgnt", d_gnt, 1'b1);
    step(0, '0, 0, '0, '0, '0, $urandom, 1);

    // Randomized traffic with requesters holding requests until granted.
    ip = 0; dp = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!ip && $urandom_range(0, 3) != 0) begin ip = 1; pa_i = $urandom; end
      else if (ip && $urandom_range(0, 15) == 0) ip = 0;
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; pa_d = $urandom; pd = $urandom;
        pw = ($urandom_range(0, 1) == 0) ? '0 : BE_W'($urandom);
      end else if (dp && $urandom_range(0, 15) == 0) dp = 0;
      step(ip, ip ? pa_i : '0, dp, dp ? pw : '0, dp ? pa_d : '0, dp ? pd : '0,
           $urandom, 1);
      if (last_ig) ip = 0;
      if (last_dg) dp = 0;
    end

    // Saturation: both ports held long enough to overflow a 16-bit counter.
    for (int n = 0; n < 70000; n++)
      step(1, 32'h600, 1, '0, 32'h700, '0, $urandom, (n % 4096) == 0);
    step(1, 32'h600, 1, '0, 32'h700, '0, $urandom, 1);
    check_val("conflict_sat", conflict_cnt, CNT_MAX);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
